// File: rtl/rx_frame_chk.sv
// ---------------------------------------------------------------------------
// rx_frame_chk
//
// Receive-side frame checker for an oversampled UART-style serial line. The
// bit timing (edge_cnt / bit_done) comes from an external bit-timer. This
// block majority-votes each bit, walks the data, parity and stop fields, and
// reports sticky parity and stop errors plus a one-cycle end-of-frame pulse.
//
// Parameters
//   DATA_W   : data bits per frame (5..9)
//   PRESC_W  : width of Prescale and edge_cnt
//
// Ports
//   clk        in   sole clock, rising edge
//   ARST_n     in   synchronous active-low reset
//   start_chk  in   one-cycle pulse: start bit accepted, data phase begins
//   rx_in      in   serial line, already synchronised to clk
//   edge_cnt   in   oversample index within the current bit
//   bit_done   in   one-cycle pulse on the last oversample of a bit
//   Prescale   in   oversample ratio (even, >= 4)
//   par_en     in   parity bit present (latched on start_chk)
//   par_typ    in   0 = even, 1 = odd (latched on start_chk)
//   stop2      in   two stop bits expected (latched on start_chk)
//   err_clr    in   clears the sticky error flags
//   par_err    out  sticky parity error
//   stp_err    out  sticky stop error
//   frame_done out  one-cycle pulse at frame end
//   busy       out  high whenever the checker is not idle
// ---------------------------------------------------------------------------
module rx_frame_chk #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               ARST_n,
    input  logic               start_chk,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic               bit_done,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               par_en,
    input  logic               par_typ,
    input  logic               stop2,
    input  logic               err_clr,
    output logic               par_err,
    output logic               stp_err,
    output logic               frame_done,
    output logic               busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic               acc_q,        acc_d;
    logic               smp_a_q,      smp_a_d;
    logic               smp_b_q,      smp_b_d;
    logic               vote_q,       vote_d;
    logic               par_en_q,     par_en_d;
    logic               par_typ_q,    par_typ_d;
    logic               stop2_q,      stop2_d;
    logic               par_err_q,    par_err_d;
    logic               stp_err_q,    stp_err_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q,       busy_d;

    // ------------------------------------------------------------------
    // Majority-vote sampler around the bit centre
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] half;
    logic [PRESC_W-1:0] pt_a;
    logic [PRESC_W-1:0] pt_b;
    logic [PRESC_W-1:0] pt_c;
    logic               third_now;
    logic               maj_now;

    always_comb begin
        half      = Prescale >> 1;
        pt_a      = half - PRESC_W'(1);
        pt_b      = half;
        pt_c      = half + PRESC_W'(1);
        third_now = (edge_cnt == pt_c);

        // The third sample is taken straight from rx_in rather than from a
        // flop so that the vote lands in the same edge as the third sample.
        maj_now = (smp_a_q & smp_b_q) | (smp_a_q & rx_in) | (smp_b_q & rx_in);

        smp_a_d = smp_a_q;
        smp_b_d = smp_b_q;
        vote_d  = vote_q;
        if (edge_cnt == pt_a) begin
            smp_a_d = rx_in;
        end
        if (edge_cnt == pt_b) begin
            smp_b_d = rx_in;
        end
        if (third_now) begin
            vote_d = maj_now;
        end
    end

    // With Prescale = 4 the third sample coincides with bit_done, so the
    // FSM consumes the next-value of the vote; for larger ratios vote_d
    // simply equals the held vote_q by the time bit_done arrives.
    logic bit_vote;
    assign bit_vote = vote_d;

    // ------------------------------------------------------------------
    // Frame FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        acc_d     = acc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;

        // err_clr drops the flags; any setting event below overrides it.
        par_err_d = err_clr ? 1'b0 : par_err_q;
        stp_err_d = err_clr ? 1'b0 : stp_err_q;

        if (start_chk) begin
            // Start (or restart, aborting any frame in flight). A bit_done
            // in the same cycle is deliberately discarded.
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            acc_d     = 1'b0;
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
            par_en_d  = par_en;
            par_typ_d = par_typ;
            stop2_d   = stop2;
        end else begin
            case (state_q)
                ST_DATA: begin
                    if (bit_done) begin
                        acc_d     = acc_q ^ bit_vote;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = par_en_q ? ST_PARITY : ST_STOP1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        if (bit_vote != (acc_q ^ par_typ_q)) begin
                            par_err_d = 1'b1;
                        end
                        state_d = ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (bit_done) begin
                        if (!bit_vote) begin
                            stp_err_d = 1'b1;
                        end
                        state_d = stop2_q ? ST_STOP2 : ST_DONE;
                    end
                end
                ST_STOP2: begin
                    if (bit_done) begin
                        if (!bit_vote) begin
                            stp_err_d = 1'b1;
                        end
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    // ST_IDLE: bit_done is ignored here.
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with
        // the state register itself.
        frame_done_d = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!ARST_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            acc_q        <= 1'b0;
            smp_a_q      <= 1'b0;
            smp_b_q      <= 1'b0;
            vote_q       <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            stop2_q      <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            acc_q        <= acc_d;
            smp_a_q      <= smp_a_d;
            smp_b_q      <= smp_b_d;
            vote_q       <= vote_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            stop2_q      <= stop2_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
